// File: rtl/ser_par_pkg.sv
// Shared definitions for the serial/parallel converter pair (par2ser and
// the matching serial-to-parallel receiver).
//   - ser_state_t   : IDLE/SHIFT state encoding of the serialiser
//   - DIR_*         : bit-order codes carried on the 'direct' input
//   - bit_reverse() : reverses the low n bits of a word (n <= MAX_W)
package ser_par_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_t;

  localparam logic DIR_LSB_FIRST = 1'b0;
  localparam logic DIR_MSB_FIRST = 1'b1;

  // Widest word bit_reverse() can handle; callers zero-extend to this width.
  localparam int MAX_W = 64;

  // Bit n-1-i of v lands on bit i; bits at and above n come back as zero.
  function automatic logic [MAX_W-1:0] bit_reverse(input logic [MAX_W-1:0] v,
                                                   input int n);
    logic [MAX_W-1:0] r;
    logic [MAX_W-1:0] tmp;
    r = '0;
    for (int i = 0; i < MAX_W; i++) begin
      if (i < n) begin
        tmp  = v >> (n - 1 - i);
        r[i] = tmp[0];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/par2ser_if.sv
// Handshake bundle of the parallel-to-serial converter.
//   Word side  : direct, ivalid, idata (to block), iready (from block)
//   Serial side: ovalid, odata, olast (from block), oready (to block)
// modport slave  - the converter itself
// modport master - the environment: word producer and serial consumer
interface par2ser_if #(
  parameter int LENGTH = 8
);
  logic              direct;
  logic              ivalid;
  logic              iready;
  logic [LENGTH-1:0] idata;
  logic              ovalid;
  logic              oready;
  logic              odata;
  logic              olast;

  modport slave (
    input  direct, ivalid, idata, oready,
    output iready, ovalid, odata, olast
  );

  modport master (
    output direct, ivalid, idata, oready,
    input  iready, ovalid, odata, olast
  );
endinterface

// File: rtl/par2ser_hold.sv
// One-entry holding buffer for par2ser: keeps one accepted word and its
// bit-order flag while the shifter is still busy with the previous word.
// Ports:
//   clock, reset         : rising-edge clock, synchronous active-low reset
//   push, push_data/dir  : store a word (sets full)
//   pop                  : contents consumed by the shifter (clears full)
//   full, data, dir      : buffer state and contents
// push and pop in the same cycle is legal: the old contents are read out
// by the shifter and the new word takes their place.
module par2ser_hold #(
  parameter int LENGTH = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              push,
  input  logic [LENGTH-1:0] push_data,
  input  logic              push_dir,
  input  logic              pop,
  output logic              full,
  output logic [LENGTH-1:0] data,
  output logic              dir
);

  always_ff @(posedge clock) begin
    if (!reset) begin
      full <= 1'b0;
      data <= '0;
      dir  <= 1'b0;
    end else if (push) begin
      full <= 1'b1;
      data <= push_data;
      dir  <= push_dir;
    end else if (pop) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/par2ser.sv
// Parallel-to-serial converter.
// Accepts LENGTH-bit words over a ready/valid handshake and emits them one
// bit per transfer on a valid/ready serial port, flagging the final bit of
// every word with olast. A one-word holding buffer lets consecutive words
// stream with no idle bit slots.
// Ports:
//   clock : rising-edge clock
//   reset : synchronous, active-low
//   bus   : par2ser_if.slave (direct/ivalid/iready/idata, ovalid/oready/odata/olast)
// Supported widths: 2 <= LENGTH <= ser_par_pkg::MAX_W.
module par2ser
  import ser_par_pkg::*;
#(
  parameter int LENGTH = 8
) (
  input  logic       clock,
  input  logic       reset,
  par2ser_if.slave   bus
);

  localparam int CW = $clog2(LENGTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(LENGTH - 1);

  ser_state_t        state;
  ser_state_t        state_nxt;
  logic [LENGTH-1:0] sh;
  logic [CW-1:0]     cnt;

  logic              busy;
  logic              accept;
  logic              xfer;
  logic              last_xfer;
  logic              shifter_free;
  logic              load_hold;
  logic              load_in;
  logic              load;
  logic              push;
  logic [LENGTH-1:0] load_word;
  logic              load_dir;

  logic              hold_full;
  logic [LENGTH-1:0] hold_data;
  logic              hold_dir;

  assign busy = (state == SHIFT);

  // Depends only on the reset pin and a register, never on oready.
  assign bus.iready = reset & ~hold_full;
  assign accept     = bus.ivalid & bus.iready;

  assign xfer         = busy & bus.oready;
  assign last_xfer    = xfer & (cnt == CNT_LAST);
  assign shifter_free = ~busy | last_xfer;

  // The buffered word is always older than anything on the input, so it
  // has first claim on a free shifter.
  assign load_hold = shifter_free & hold_full;
  assign load_in   = shifter_free & ~hold_full & accept;
  assign load      = load_hold | load_in;
  assign push      = accept & ~load_in;

  // idata only reaches state when load_in or push is set.
  assign load_word = load_hold ? hold_data : bus.idata;
  assign load_dir  = load_hold ? hold_dir  : bus.direct;

  par2ser_hold #(
    .LENGTH (LENGTH)
  ) u_hold (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data (bus.idata),
    .push_dir  (bus.direct),
    .pop       (load_hold),
    .full      (hold_full),
    .data      (hold_data),
    .dir       (hold_dir)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (load) state_nxt = SHIFT;
      SHIFT:   if (last_xfer && !load) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.ovalid = 1'b0;
    bus.olast  = 1'b0;
    bus.odata  = sh[0];
    if (state == SHIFT) begin
      bus.ovalid = 1'b1;
      bus.olast  = (cnt == CNT_LAST);
    end
  end

  // Words sent MSB first are reversed on the way in so the serial output
  // is always sh[0] with a right shift; zeros fill from the top, leaving
  // the register clear once a word has fully drained.
  always_ff @(posedge clock) begin
    if (!reset) begin
      sh  <= '0;
      cnt <= '0;
    end else begin
      if (load) begin
        if (load_dir == DIR_MSB_FIRST) begin
          sh <= LENGTH'(bit_reverse(MAX_W'(load_word), LENGTH));
        end else begin
          sh <= load_word;
        end
      end else if (xfer) begin
        sh <= sh >> 1;
      end

      if (load || last_xfer) begin
        cnt <= '0;
      end else if (xfer) begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_par2ser.sv
// Bench for par2ser: a queue model of the pending serial bits, a per-cycle
// compare against it, a loopback receiver, and literal expectations for the
// directed words.
module tb_par2ser;
  localparam int LENGTH = 8;

  typedef struct {
    logic b;
    logic l;
  } mbit_t;

  typedef struct {
    logic [LENGTH-1:0] w;
    logic              d;
  } sent_t;

  logic clock = 1'b0;
  logic reset = 1'b0;

  par2ser_if #(.LENGTH(LENGTH)) bus_if ();

  par2ser #(.LENGTH(LENGTH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus_if)
  );

  always #5 clock = ~clock;

  int vectors     = 0;
  int miscompares = 0;

  mbit_t q[$];
  sent_t sent_q[$];
  logic  rx_bits[$];
  int    rx_words = 0;

  logic [31:0] cap;
  logic [31:0] lastpat;
  int          ncap;
  int          cyc = 0;
  int          first_v;
  int          last_v;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: every accepted word appends its LENGTH bits in send order;
  // every serial transfer removes the oldest bit. The block can take a word
  // whenever no more than one word's worth of bits is still pending.
  always @(posedge clock) begin
    mbit_t e;
    logic  acc;
    if (!reset) begin
      q.delete();
      sent_q.delete();
      rx_bits.delete();
    end else begin
      acc = bus_if.ivalid && (q.size() <= LENGTH);
      if (q.size() > 0 && bus_if.oready) void'(q.pop_front());
      if (acc) begin
        for (int i = 0; i < LENGTH; i++) begin
          e.b = bus_if.direct ? bus_if.idata[LENGTH-1-i] : bus_if.idata[i];
          e.l = (i == LENGTH - 1);
          q.push_back(e);
        end
      end
    end
  end

  // Per-cycle compare, capture and loopback receiver.
  always @(negedge clock) begin
    sent_t            s;
    logic [LENGTH-1:0] rw;
    cyc++;
    check("ovalid", bus_if.ovalid, q.size() > 0);
    check("iready", bus_if.iready, reset && (q.size() <= LENGTH));
    if (q.size() > 0) begin
      check("odata", bus_if.odata, q[0].b);
      check("olast", bus_if.olast, q[0].l);
    end else begin
      check("olast_idle", bus_if.olast, 1'b0);
    end
    if (bus_if.ovalid) begin
      if (first_v < 0) first_v = cyc;
      last_v = cyc;
    end
    if (bus_if.ovalid && bus_if.oready) begin
      cap     = {cap[30:0], bus_if.odata};
      lastpat = {lastpat[30:0], bus_if.olast};
      ncap++;
      rx_bits.push_back(bus_if.odata);
      if (bus_if.olast) begin
        check("rx_len", rx_bits.size(), LENGTH);
        if (sent_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL rx_word: word received with none outstanding (t=%0t)", $time);
        end else if (rx_bits.size() == LENGTH) begin
          s  = sent_q.pop_front();
          rw = '0;
          for (int i = 0; i < LENGTH; i++) begin
            if (s.d) rw[LENGTH-1-i] = rx_bits[i];
            else     rw[i]          = rx_bits[i];
          end
          check("rx_word", rw, s.w);
          rx_words++;
        end
        rx_bits.delete();
      end
    end
  end

  task automatic clear_cap();
    cap     = '0;
    lastpat = '0;
    ncap    = 0;
    first_v = -1;
    last_v  = -1;
  endtask

  // Presents a word and returns at posedge+2 after the edge that took it.
  task automatic send(input logic [LENGTH-1:0] w, input logic d);
    logic rdy;
    int   k;
    bus_if.ivalid = 1'b1;
    bus_if.idata  = w;
    bus_if.direct = d;
    for (k = 0; k < 100; k++) begin
      @(negedge clock);
      rdy = bus_if.iready;
      @(posedge clock);
      #2;
      if (rdy) break;
    end
    if (k == 100) begin
      vectors++;
      miscompares++;
      $display("FAIL send_timeout: word %0h not accepted, required within 100 cycles", w);
    end else begin
      sent_q.push_back('{w, d});
    end
  endtask

  task automatic drop_input();
    bus_if.ivalid = 1'b0;
    bus_if.idata  = 'x;
    bus_if.direct = 1'bx;
  endtask

  task automatic wait_idle();
    int k;
    for (k = 0; k < 300; k++) begin
      @(negedge clock);
      if (!bus_if.ovalid) break;
    end
    if (k == 300) begin
      vectors++;
      miscompares++;
      $display("FAIL idle_timeout: ovalid still 1, required 0 within 300 cycles");
    end
    @(posedge clock);
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, miscompares=%0d", miscompares);
    $fatal(1);
  end

  initial begin
    clear_cap();
    bus_if.ivalid = 1'b0;
    bus_if.idata  = '0;
    bus_if.direct = 1'b0;
    bus_if.oready = 1'b1;
    reset         = 1'b0;

    // Reset state
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_ovalid", bus_if.ovalid, 1'b0);
    check("rst_olast",  bus_if.olast,  1'b0);
    check("rst_odata",  bus_if.odata,  1'b0);
    check("rst_iready", bus_if.iready, 1'b0);
    @(posedge clock);
    #2;
    reset = 1'b1;
    drop_input();
    @(negedge clock);
    check("rel_iready", bus_if.iready, 1'b1);
    @(posedge clock);
    #2;

    // LSB first
    clear_cap();
    send(8'hD5, 1'b0);
    drop_input();
    wait_idle();
    check("lsb_bits",  cap[7:0],     8'b10101011);
    check("lsb_last",  lastpat[7:0], 8'b00000001);
    check("lsb_count", ncap,         8);

    // MSB first
    clear_cap();
    send(8'hD5, 1'b1);
    drop_input();
    wait_idle();
    check("msb_bits",  cap[7:0],     8'b11010101);
    check("msb_last",  lastpat[7:0], 8'b00000001);

    // Back-to-back
    clear_cap();
    send(8'hD5, 1'b0);
    send(8'hBB, 1'b0);
    drop_input();
    wait_idle();
    check("b2b_bits",  cap[15:0],          16'b1010101111011101);
    check("b2b_last",  lastpat[15:0],      16'b0000000100000001);
    check("b2b_span",  last_v - first_v + 1, 16);
    check("b2b_count", ncap,               16);

    // Backpressure at bit 4, second word offered during the stall
    clear_cap();
    send(8'hA5, 1'b0);
    drop_input();
    repeat (3) @(posedge clock);
    #2;
    bus_if.oready = 1'b0;
    bus_if.ivalid = 1'b1;
    bus_if.idata  = 8'h5A;
    bus_if.direct = 1'b0;
    for (int s = 0; s < 3; s++) begin
      @(negedge clock);
      check("stall_ovalid", bus_if.ovalid, 1'b1);
      check("stall_odata",  bus_if.odata,  1'b0);
      check("stall_olast",  bus_if.olast,  1'b0);
      if (s > 0) check("stall_iready", bus_if.iready, 1'b0);
      @(posedge clock);
      #2;
      if (s == 0) begin
        sent_q.push_back('{8'h5A, 1'b0});
        drop_input();
      end
    end
    bus_if.oready = 1'b1;
    wait_idle();
    check("bp_bits",  cap[15:0], 16'b1010010101011010);
    check("bp_count", ncap,      16);

    // Reset mid-word after bit 3
    clear_cap();
    send(8'hC3, 1'b0);
    drop_input();
    repeat (3) @(posedge clock);
    #2;
    reset         = 1'b0;
    bus_if.oready = 1'b0;
    @(posedge clock);
    @(negedge clock);
    check("mid_rst_ovalid", bus_if.ovalid, 1'b0);
    check("mid_rst_olast",  bus_if.olast,  1'b0);
    check("mid_rst_odata",  bus_if.odata,  1'b0);
    check("mid_rst_iready", bus_if.iready, 1'b0);
    check("mid_rst_sent",   cap[2:0],      3'b110);
    check("mid_rst_count",  ncap,          3);
    #1;
    reset         = 1'b1;
    bus_if.oready = 1'b1;
    @(posedge clock);
    #2;
    clear_cap();
    @(negedge clock);
    check("post_rst_iready", bus_if.iready, 1'b1);
    check("post_rst_quiet",  ncap,          0);
    @(posedge clock);
    #2;
    send(8'h3C, 1'b0);
    drop_input();
    wait_idle();
    check("fresh_bits",  cap[7:0], 8'b00111100);
    check("fresh_count", ncap,     8);

    // Loopback with random words and bit order
    rx_words = 0;
    for (int n = 0; n < 24; n++) begin
      send(LENGTH'($urandom), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) begin
        drop_input();
        repeat ($urandom_range(1, 12)) @(posedge clock);
        #2;
      end
    end
    drop_input();
    wait_idle();
    check("loop_words", rx_words, 24);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
